// File: rtl/start_seq.sv
// ---------------------------------------------------------------------------
// start_seq -- operation sequencer between the operator panel, the processing
// unit (PU) and the start (program address) register.
//
// Walks IDLE -> FETCH -> WAIT_PU -> ADVANCE -> CHECK and loops back to FETCH
// until a step, stop, halt or (optionally) breakpoint ends the run.
//
// Optional feature:
//   START_SEQ_BRK_EN  when defined, CHECK also stops on
//                     brk_en_from_pnl & cmp_match_from_strt and raises
//                     brk_hit_to_pnl. When undefined, both inputs are ignored
//                     and brk_hit_to_pnl stays 0.
//
// Ports:
//   clk                     clock, rising edge
//   reset                   synchronous, active-high
//   btn_run/step/stop_from_pnl  one-cycle panel pulses
//   req_arr_from_pnl        load start register from switches (IDLE only)
//   done_from_pu            PU finished (pulse); jump/halt_from_pu qualify it
//   brk_en_from_pnl         stop-on-address switch
//   cmp_match_from_strt     start register matches the switch address
//   do_arr/do_inc/do_sel_to_strt_to_strt  one-cycle start-register commands
//   start_op_to_pu          one-cycle launch of the next operation
//   running_to_pnl          high whenever the sequencer is not idle
//   brk_hit_to_pnl          run ended on an address match
//   op_cnt_to_pnl           completed-operation count, wraps silently
// ---------------------------------------------------------------------------
module start_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run_from_pnl,
    input  logic        btn_step_from_pnl,
    input  logic        btn_stop_from_pnl,
    input  logic        req_arr_from_pnl,
    input  logic        done_from_pu,
    input  logic        jump_from_pu,
    input  logic        halt_from_pu,
    input  logic        brk_en_from_pnl,
    input  logic        cmp_match_from_strt,
    output logic        do_arr_strt_to_strt,
    output logic        do_inc_strt_to_strt,
    output logic        do_sel_to_strt_to_strt,
    output logic        start_op_to_pu,
    output logic        running_to_pnl,
    output logic        brk_hit_to_pnl,
    output logic [15:0] op_cnt_to_pnl
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT_PU = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;

    logic [2:0]  state;
    logic        step_q;      // current run is a single step
    logic        stop_pend;   // stop pressed; finish current op then idle
    logic        halt_pend;   // PU reported halt with its done
    logic        jump_q;      // PU reported a jump with its done
    logic        arr_q;       // registered load-from-switches command
    logic        start_q;     // registered launch pulse
    logic        brk_hit_q;
    logic [15:0] op_cnt_q;

    logic        brk_stop;
    logic        end_run;

`ifdef START_SEQ_BRK_EN
    assign brk_stop = brk_en_from_pnl && cmp_match_from_strt;
`else
    logic unused_brk;
    assign unused_brk = brk_en_from_pnl ^ cmp_match_from_strt;
    assign brk_stop   = 1'b0;
`endif

    // A stop arriving in the CHECK cycle itself still ends the run here
    // rather than after one more operation.
    assign end_run = halt_pend || stop_pend || btn_stop_from_pnl || step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            step_q    <= 1'b0;
            stop_pend <= 1'b0;
            halt_pend <= 1'b0;
            jump_q    <= 1'b0;
            arr_q     <= 1'b0;
            start_q   <= 1'b0;
            brk_hit_q <= 1'b0;
            op_cnt_q  <= 16'h0000;
        end else begin
            arr_q   <= 1'b0;
            start_q <= 1'b0;

            if (btn_stop_from_pnl && (state != S_IDLE))
                stop_pend <= 1'b1;

            case (state)
                S_IDLE: begin
                    // A load request takes the cycle; a coincident run/step
                    // is dropped, not deferred.
                    if (req_arr_from_pnl) begin
                        arr_q <= 1'b1;
                    end else if (btn_run_from_pnl || btn_step_from_pnl) begin
                        state     <= S_FETCH;
                        step_q    <= btn_step_from_pnl;
                        stop_pend <= 1'b0;
                        halt_pend <= 1'b0;
                        brk_hit_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    start_q <= 1'b1;
                    state   <= S_WAIT_PU;
                end
                S_WAIT_PU: begin
                    if (done_from_pu) begin
                        jump_q    <= jump_from_pu;
                        halt_pend <= halt_from_pu;
                        state     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    op_cnt_q <= op_cnt_q + 16'd1;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (end_run) begin
                        state <= S_IDLE;
                    end else if (brk_stop) begin
                        state     <= S_IDLE;
                        brk_hit_q <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs come straight from registers or registered state, so the
    // four start-register/PU commands are mutually exclusive by construction.
    assign do_arr_strt_to_strt    = arr_q;
    assign start_op_to_pu         = start_q;
    assign do_inc_strt_to_strt    = (state == S_ADVANCE) && !jump_q;
    assign do_sel_to_strt_to_strt = (state == S_ADVANCE) && jump_q;
    assign running_to_pnl         = (state != S_IDLE);
    assign brk_hit_to_pnl         = brk_hit_q;
    assign op_cnt_to_pnl          = op_cnt_q;

endmodule

// File: tb/tb_start_seq.sv
// Self-checking bench for start_seq. A PU responder answers each start_op
// after a configured delay; a monitor logs every command pulse with its cycle
// number; a transaction-level model predicts the pulse list from the run rules.
module tb_start_seq;
    logic clk = 1'b0;
    logic reset, btn_run, btn_step, btn_stop, req_arr, brk_en, cmp;
    logic done = 1'b0, jump = 1'b0, halt = 1'b0;
    logic do_arr, do_inc, do_sel, start_op, running, brk_hit;
    logic [15:0] op_cnt;

    always #5 clk = ~clk;

    start_seq dut (
        .clk(clk), .reset(reset),
        .btn_run_from_pnl(btn_run), .btn_step_from_pnl(btn_step),
        .btn_stop_from_pnl(btn_stop), .req_arr_from_pnl(req_arr),
        .done_from_pu(done), .jump_from_pu(jump), .halt_from_pu(halt),
        .brk_en_from_pnl(brk_en), .cmp_match_from_strt(cmp),
        .do_arr_strt_to_strt(do_arr), .do_inc_strt_to_strt(do_inc),
        .do_sel_to_strt_to_strt(do_sel), .start_op_to_pu(start_op),
        .running_to_pnl(running), .brk_hit_to_pnl(brk_hit),
        .op_cnt_to_pnl(op_cnt)
    );

`ifdef START_SEQ_BRK_EN
    localparam bit BRK_BUILT = 1'b1;
`else
    localparam bit BRK_BUILT = 1'b0;
`endif

    localparam int K_ARR = 1, K_INC = 2, K_SEL = 3, K_START = 4;
    typedef struct { int cyc; int kind; } ev_t;

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [15:0] exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pulse monitor ----------------
    ev_t evq[$];
    int  n_start = 0, n_adv = 0, n_multi = 0;
    always @(negedge clk) begin
        ev_t e;
        e.cyc = cyc;
        if (int'(do_arr) + int'(do_inc) + int'(do_sel) + int'(start_op) > 1) n_multi++;
        if (do_arr)   begin e.kind = K_ARR;   evq.push_back(e); end
        if (start_op) begin e.kind = K_START; evq.push_back(e); n_start++; end
        if (do_inc)   begin e.kind = K_INC;   evq.push_back(e); n_adv++; end
        if (do_sel)   begin e.kind = K_SEL;   evq.push_back(e); n_adv++; end
    end

    // ---------------- PU responder ----------------
    int pu_delay[16];
    bit pu_jump[16], pu_halt[16];
    int pu_idx = 0, pu_cnt = 0;
    bit pu_pend = 1'b0, pu_force = 1'b0;
    always @(posedge clk) begin
        #2;
        done = 1'b0; jump = 1'b0; halt = 1'b0;
        if (reset || !running) begin pu_pend = 1'b0; pu_idx = 0; end
        if (pu_force) begin
            done = 1'b1;
        end else if (pu_pend) begin
            pu_cnt--;
            if (pu_cnt == 0) begin
                done = 1'b1; jump = pu_jump[pu_idx]; halt = pu_halt[pu_idx];
                pu_idx++; pu_pend = 1'b0;
            end
        end
        if (start_op && !reset) begin pu_pend = 1'b1; pu_cnt = pu_delay[pu_idx]; end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg_random();
        for (int i = 0; i < 16; i++) begin
            pu_delay[i] = int'($urandom_range(1, 5));
            pu_jump[i]  = 1'($urandom_range(0, 1));
            pu_halt[i]  = 1'b0;
        end
    endtask

    // Reference model: how many operations the run performs, and the exact
    // pulse list. Op i launches at s, its done comes d cycles later, the
    // start register is advanced the cycle after, and the next launch follows
    // after CHECK and FETCH (3 cycles). The first launch is 2 cycles after
    // the accepted button.
    function automatic void model(input int c0, input bit step, input int stop_op,
                                  input int cmp_adv, input bit brk_on,
                                  output int n, output bit brk_exp, output ev_t q[$]);
        int s, a;
        ev_t e;
        n = 1000; brk_exp = 1'b0; q = {};
        if (step) n = 1;
        for (int i = 0; i < 16; i++) if (pu_halt[i] && i + 1 < n) n = i + 1;
        if (stop_op > 0 && stop_op < n) n = stop_op;
        if (brk_on && cmp_adv > 0 && cmp_adv < n) begin n = cmp_adv; brk_exp = 1'b1; end
        s = c0 + 2;
        for (int i = 0; i < n; i++) begin
            e.cyc = s; e.kind = K_START; q.push_back(e);
            a = s + pu_delay[i] + 1;
            e.cyc = a; e.kind = pu_jump[i] ? K_SEL : K_INC; q.push_back(e);
            s = a + 3;
        end
    endfunction

    // Launches a run and drives panel stimulus keyed on observed progress:
    // stop / run+req_arr go in during WAIT_PU of the given op, cmp rises for
    // the CHECK following the given ADVANCE.
    task automatic do_run(input bit step, input int stop_op, input int cmp_adv,
                          input int poke_op, output int c0, output int b,
                          output bit brk_fetch, output bit to);
        int bs, ba;
        bit seen, fin, sdone, pdone;
        b = evq.size(); bs = n_start; ba = n_adv;
        fin = 1'b0; sdone = 1'b0; pdone = 1'b0;
        c0 = cyc;
        btn_step = step; btn_run = !step;
        tick();
        btn_step = 1'b0; btn_run = 1'b0;
        brk_fetch = brk_hit; seen = running;
        for (int t = 0; t < 400 && !fin; t++) begin
            btn_stop = 1'b0; btn_run = 1'b0; req_arr = 1'b0;
            if (stop_op > 0 && !sdone && n_start - bs == stop_op) begin btn_stop = 1'b1; sdone = 1'b1; end
            if (poke_op > 0 && !pdone && n_start - bs == poke_op) begin
                btn_run = 1'b1; req_arr = 1'b1; pdone = 1'b1;
            end
            if (cmp_adv > 0 && n_adv - ba >= cmp_adv) cmp = 1'b1;
            tick();
            if (running) seen = 1'b1; else if (seen) fin = 1'b1;
        end
        btn_stop = 1'b0; btn_run = 1'b0; req_arr = 1'b0; cmp = 1'b0;
        to = !fin;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        checks += 7;
        if (running !== 1'b0)  begin failures++; $display("FAIL reset running: got %b want 0", running); end
        if (start_op !== 1'b0) begin failures++; $display("FAIL reset start_op: got %b want 0", start_op); end
        if (do_arr !== 1'b0)   begin failures++; $display("FAIL reset do_arr: got %b want 0", do_arr); end
        if (do_inc !== 1'b0)   begin failures++; $display("FAIL reset do_inc: got %b want 0", do_inc); end
        if (do_sel !== 1'b0)   begin failures++; $display("FAIL reset do_sel: got %b want 0", do_sel); end
        if (brk_hit !== 1'b0)  begin failures++; $display("FAIL reset brk_hit: got %b want 0", brk_hit); end
        if (op_cnt !== 16'h0)  begin failures++; $display("FAIL reset op_cnt: got %h want 0000", op_cnt); end
        reset = 1'b0; exp_cnt = 16'h0;
    endtask

    task automatic test_req_arr();
        int b, c0;
        for (int k = 0; k < 3; k++) begin
            // k=0: plain load; k=1: with run; k=2: with step -- only the load is served
            b = evq.size(); c0 = cyc;
            req_arr = 1'b1; btn_run = (k == 1); btn_step = (k == 2);
            tick();
            req_arr = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
            checks++;
            if (running !== 1'b0) begin failures++; $display("FAIL req_arr%0d running: got %b want 0", k, running); end
            repeat (3) tick();
            checks++;
            if (evq.size() - b != 1) begin
                failures++; $display("FAIL req_arr%0d pulses: got %0d want 1", k, evq.size() - b);
            end else begin
                checks++;
                if (evq[b].kind != K_ARR || evq[b].cyc != c0 + 1) begin
                    failures++;
                    $display("FAIL req_arr%0d pulse: got kind=%0d cyc=%0d want kind=%0d cyc=%0d",
                             k, evq[b].kind, evq[b].cyc, K_ARR, c0 + 1);
                end
            end
            checks++;
            if (op_cnt !== exp_cnt) begin failures++; $display("FAIL req_arr%0d op_cnt: got %h want %h", k, op_cnt, exp_cnt); end
        end
    endtask

    task automatic test_step();
        int c0, b, n; bit bf, to, be; ev_t eq[$];
        cfg_random(); pu_delay[0] = 3; pu_jump[0] = 1'b0;
        do_run(1'b1, 0, 0, 0, c0, b, bf, to);
        model(c0, 1'b1, 0, 0, 1'b0, n, be, eq);
        checks++; if (to) begin failures++; $display("FAIL step timeout: run did not return to idle"); end
        checks++;
        if (evq.size() - b != eq.size()) begin failures++; $display("FAIL step ev_count: got %0d want %0d", evq.size() - b, eq.size()); end
        for (int i = 0; i < eq.size() && b + i < evq.size(); i++) begin
            checks++;
            if (evq[b+i].cyc != eq[i].cyc || evq[b+i].kind != eq[i].kind) begin
                failures++;
                $display("FAIL step ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d",
                         i, evq[b+i].cyc, evq[b+i].kind, eq[i].cyc, eq[i].kind);
            end
        end
        exp_cnt = exp_cnt + 16'(n);
        checks++; if (op_cnt !== exp_cnt) begin failures++; $display("FAIL step op_cnt: got %h want %h", op_cnt, exp_cnt); end
    endtask

    task automatic test_run_stop();
        int c0, b, n; bit bf, to, be; ev_t eq[$];
        cfg_random();
        pu_jump[0] = 1'b0; pu_jump[1] = 1'b1; pu_jump[2] = 1'b0; pu_jump[3] = 1'b0;
        do_run(1'b0, 4, 0, 0, c0, b, bf, to);
        model(c0, 1'b0, 4, 0, 1'b0, n, be, eq);
        checks++; if (to) begin failures++; $display("FAIL run_stop timeout: run did not return to idle"); end
        checks++;
        if (evq.size() - b != eq.size()) begin failures++; $display("FAIL run_stop ev_count: got %0d want %0d", evq.size() - b, eq.size()); end
        for (int i = 0; i < eq.size() && b + i < evq.size(); i++) begin
            checks++;
            if (evq[b+i].cyc != eq[i].cyc || evq[b+i].kind != eq[i].kind) begin
                failures++;
                $display("FAIL run_stop ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d",
                         i, evq[b+i].cyc, evq[b+i].kind, eq[i].cyc, eq[i].kind);
            end
        end
        exp_cnt = exp_cnt + 16'(n);
        checks++; if (op_cnt !== exp_cnt) begin failures++; $display("FAIL run_stop op_cnt: got %h want %h", op_cnt, exp_cnt); end
    endtask

    task automatic test_brk();
        int c0, b, n; bit bf, to, be; ev_t eq[$];
        brk_en = 1'b1;
        cfg_random();
        do_run(1'b0, 4, 2, 0, c0, b, bf, to);
        model(c0, 1'b0, 4, 2, BRK_BUILT, n, be, eq);
        checks++; if (to) begin failures++; $display("FAIL brk timeout: run did not return to idle"); end
        checks++;
        if (evq.size() - b != eq.size()) begin failures++; $display("FAIL brk ev_count: got %0d want %0d", evq.size() - b, eq.size()); end
        for (int i = 0; i < eq.size() && b + i < evq.size(); i++) begin
            checks++;
            if (evq[b+i].cyc != eq[i].cyc || evq[b+i].kind != eq[i].kind) begin
                failures++;
                $display("FAIL brk ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d",
                         i, evq[b+i].cyc, evq[b+i].kind, eq[i].cyc, eq[i].kind);
            end
        end
        checks++; if (brk_hit !== be) begin failures++; $display("FAIL brk brk_hit: got %b want %b", brk_hit, be); end
        exp_cnt = exp_cnt + 16'(n);
        checks++; if (op_cnt !== exp_cnt) begin failures++; $display("FAIL brk op_cnt: got %h want %h", op_cnt, exp_cnt); end
        // the next accepted run clears the flag by its FETCH cycle
        cfg_random();
        do_run(1'b0, 1, 0, 0, c0, b, bf, to);
        model(c0, 1'b0, 1, 0, 1'b0, n, be, eq);
        checks++; if (bf !== 1'b0) begin failures++; $display("FAIL brk_clear brk_hit: got %b want 0", bf); end
        checks++;
        if (evq.size() - b != eq.size()) begin failures++; $display("FAIL brk_clear ev_count: got %0d want %0d", evq.size() - b, eq.size()); end
        exp_cnt = exp_cnt + 16'(n);
        brk_en = 1'b0;
    endtask

    task automatic test_halt_wrap();
        int c0, b, n; bit bf, to, be; ev_t eq[$];
        force dut.op_cnt_q = 16'hFFFE;
        tick();
        release dut.op_cnt_q;
        tick();
        exp_cnt = 16'hFFFE;
        checks++; if (op_cnt !== exp_cnt) begin failures++; $display("FAIL wrap preload: got %h want %h", op_cnt, exp_cnt); end
        cfg_random(); pu_halt[1] = 1'b1;
        do_run(1'b0, 0, 0, 2, c0, b, bf, to);
        model(c0, 1'b0, 0, 0, 1'b0, n, be, eq);
        checks++; if (to) begin failures++; $display("FAIL halt timeout: run did not return to idle"); end
        checks++;
        if (evq.size() - b != eq.size()) begin failures++; $display("FAIL halt ev_count: got %0d want %0d", evq.size() - b, eq.size()); end
        for (int i = 0; i < eq.size() && b + i < evq.size(); i++) begin
            checks++;
            if (evq[b+i].cyc != eq[i].cyc || evq[b+i].kind != eq[i].kind) begin
                failures++;
                $display("FAIL halt ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d",
                         i, evq[b+i].cyc, evq[b+i].kind, eq[i].cyc, eq[i].kind);
            end
        end
        exp_cnt = exp_cnt + 16'(n);
        checks++; if (op_cnt !== 16'h0000) begin failures++; $display("FAIL wrap op_cnt: got %h want 0000", op_cnt); end
    endtask

    task automatic test_random();
        int c0, b, n, st, h, pk; bit bf, to, be, sp; ev_t eq[$];
        for (int it = 0; it < 6; it++) begin
            cfg_random();
            h  = int'($urandom_range(0, 6));
            if (h > 0) pu_halt[h-1] = 1'b1;
            st = int'($urandom_range(1, 6));
            sp = ($urandom_range(0, 3) == 0);
            pk = int'($urandom_range(0, 3));
            do_run(sp, st, 0, pk, c0, b, bf, to);
            model(c0, sp, st, 0, 1'b0, n, be, eq);
            checks++; if (to) begin failures++; $display("FAIL rand%0d timeout: run did not return to idle", it); end
            checks++;
            if (evq.size() - b != eq.size()) begin
                failures++; $display("FAIL rand%0d ev_count: got %0d want %0d", it, evq.size() - b, eq.size());
            end
            for (int i = 0; i < eq.size() && b + i < evq.size(); i++) begin
                checks++;
                if (evq[b+i].cyc != eq[i].cyc || evq[b+i].kind != eq[i].kind) begin
                    failures++;
                    $display("FAIL rand%0d ev%0d: got cyc=%0d kind=%0d want cyc=%0d kind=%0d",
                             it, i, evq[b+i].cyc, evq[b+i].kind, eq[i].cyc, eq[i].kind);
                end
            end
            exp_cnt = exp_cnt + 16'(n);
            checks++; if (op_cnt !== exp_cnt) begin failures++; $display("FAIL rand%0d op_cnt: got %h want %h", it, op_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_inflight();
        int b, bs, adv;
        cfg_random(); pu_delay[0] = 40;
        b = evq.size(); bs = n_start;
        btn_run = 1'b1; tick(); btn_run = 1'b0;
        for (int t = 0; t < 20 && n_start == bs; t++) tick();
        repeat (3) tick();
        reset = 1'b1; pu_force = 1'b1;   // done coincides with reset
        tick();
        reset = 1'b0; pu_force = 1'b0;
        checks += 6;
        if (running !== 1'b0)  begin failures++; $display("FAIL rst_wait running: got %b want 0", running); end
        if (start_op !== 1'b0) begin failures++; $display("FAIL rst_wait start_op: got %b want 0", start_op); end
        if (do_inc !== 1'b0)   begin failures++; $display("FAIL rst_wait do_inc: got %b want 0", do_inc); end
        if (do_sel !== 1'b0)   begin failures++; $display("FAIL rst_wait do_sel: got %b want 0", do_sel); end
        if (do_arr !== 1'b0)   begin failures++; $display("FAIL rst_wait do_arr: got %b want 0", do_arr); end
        if (op_cnt !== 16'h0)  begin failures++; $display("FAIL rst_wait op_cnt: got %h want 0000", op_cnt); end
        repeat (5) tick();
        adv = 0;
        for (int i = b; i < evq.size(); i++) if (evq[i].kind == K_INC || evq[i].kind == K_SEL) adv++;
        checks++; if (adv != 0) begin failures++; $display("FAIL rst_wait advances: got %0d want 0", adv); end
        checks++; if (n_start - bs != 1) begin failures++; $display("FAIL rst_wait starts: got %0d want 1", n_start - bs); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL rst_wait idle: got running=%b want 0", running); end
        exp_cnt = 16'h0;
    endtask

    initial begin
        btn_run = 1'b0; btn_step = 1'b0; btn_stop = 1'b0; req_arr = 1'b0;
        brk_en = 1'b0; cmp = 1'b0; reset = 1'b1; exp_cnt = 16'h0;
        test_reset();
        test_req_arr();
        test_step();
        test_run_stop();
        test_brk();
        test_halt_wrap();
        test_random();
        test_reset_inflight();
        checks++;
        if (n_multi != 0) begin failures++; $display("FAIL exclusive_cmds: got %0d overlapping cycles want 0", n_multi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/start_seq.md
START_SEQ -- requirements
Module: start_seq

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide ports: btn_run_from_pnl, btn_step_from_pnl, btn_stop_from_pnl  in  1 each  one-cycle panel pulses.
REQ-004 SHALL provide ports: req_arr_from_pnl  in  1  panel request to load start register from switches.
REQ-005 SHALL provide ports: done_from_pu  in  1  PU finished current operation (one-cycle pulse); jump_from_pu, halt_from_pu  in  1  qualifiers sampled with done_from_pu.
REQ-006 SHALL provide ports: brk_en_from_pnl  in  1  stop-on-address switch; cmp_match_from_strt  in  1  start-register compare result.
REQ-007 SHALL provide ports: do_arr_strt_to_strt, do_inc_strt_to_strt, do_sel_to_strt_to_strt  out  1 each  one-cycle start-register commands.
REQ-008 SHALL provide ports: start_op_to_pu  out  1  one-cycle pulse launching next operation.
REQ-009 SHALL provide ports: running_to_pnl  out  1; brk_hit_to_pnl  out  1; op_cnt_to_pnl  out  16  completed-operation count.

Function
REQ-010 SHALL implement states IDLE, FETCH, WAIT_PU, ADVANCE, CHECK; outputs decoded from registered state/flags only.
REQ-011 IDLE: req_arr_from_pnl SHALL set do_arr_strt_to_strt high for exactly the next cycle; state stays IDLE.
REQ-012 IDLE: req_arr and run/step in same cycle SHALL serve req_arr only; run/step dropped.
REQ-013 IDLE: btn_step SHALL go to FETCH with step flag set; btn_run SHALL go to FETCH with step flag clear; step wins if both.
REQ-014 run/step acceptance SHALL clear brk_hit_to_pnl, stop-pending and halt-pending flags.
REQ-015 FETCH: start_op_to_pu high one cycle, next state WAIT_PU; run pulse to start_op latency = 2 cycles.
REQ-016 WAIT_PU: hold until done_from_pu; at done latch jump_from_pu and halt_from_pu, go ADVANCE.
REQ-017 ADVANCE: exactly one of do_sel_to_strt_to_strt (jump latched) or do_inc_strt_to_strt (else) high one cycle; op_cnt increments; next CHECK.
REQ-018 op_cnt SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-019 CHECK (start register already updated): priority halt-pending, stop-pending, step flag -> IDLE; else brk match -> IDLE; else -> FETCH.
REQ-020 btn_stop in any non-IDLE state SHALL set stop-pending; current operation completes, no abort; btn_stop in IDLE ignored.
REQ-021 run/step/req_arr outside IDLE SHALL be ignored (not queued).
REQ-022 running_to_pnl SHALL be high in every state except IDLE.
REQ-023 At most one of do_arr/do_inc/do_sel/start_op SHALL be high in any cycle.

Reset
REQ-024 reset SHALL force IDLE, clear all flags, op_cnt=0, all outputs 0 on next cycle, overriding any in-flight operation or pulse.
REQ-025 reset asserted mid-WAIT_PU SHALL discard a coincident done_from_pu.

Configuration
REQ-026 Macro START_SEQ_BRK_EN defined: CHECK stops when brk_en_from_pnl & cmp_match_from_strt, setting brk_hit_to_pnl=1 until next accepted run/step or reset.
REQ-027 Macro START_SEQ_BRK_EN undefined: brk_en_from_pnl and cmp_match_from_strt ignored; brk_hit_to_pnl tied 0; CHECK never stops on match.

Verification
REQ-028 Reset, req_arr in IDLE -> do_arr pulse next cycle only, running=0, op_cnt=0.
REQ-029 btn_step, PU done 3 cycles after start_op, jump=0 -> one start_op, one do_inc, return IDLE, op_cnt=1.
REQ-030 btn_run, 4 ops with jump=1 on 2nd -> do_inc,do_sel,do_inc,do_inc sequence; btn_stop during 4th WAIT_PU -> IDLE after 4th ADVANCE, op_cnt=4.
REQ-031 BRK_EN defined, brk_en=1, cmp_match rises after 2nd ADVANCE -> IDLE after 2 ops, brk_hit=1; next btn_run clears brk_hit. Undefined -> run continues.
REQ-032 halt_from_pu=1 with done, plus btn_run and req_arr in WAIT_PU -> ADVANCE then IDLE; run/req_arr produce no pulses; op_cnt 16'hFFFF wraps to 0.
REQ-033 reset during WAIT_PU with coincident done -> no do_inc/do_sel, IDLE, all outputs 0.
